joypad_poller: RTL and testbench

- Autonomous multi-controller poller placed between a serial controller bridge (I2C/NES-style reader with start/ready/valid handshake) and the CPU/LED fabric.
- Periodically sweeps NUM_CH controllers through one shared bridge and debounces each sample.
- Keeps stable button state per channel, raises sticky press/release events with an IRQ, and flags a per-channel error on bridge timeout.
- Generalises the single-controller "start on ready, latch on valid" loop.

---
 rtl/joypad_poller.sv | 197 +++++++++++++++++++
 tb/tb_joypad_poller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joypad_poller.sv
// joypad_poller: sweeps NUM_CH controllers through one shared serial bridge, debounces
// every sample and reports stable state, sticky press/release events and timeouts.
module joypad_poller #(
  parameter int NUM_CH         = 2,
  parameter int BTN_W          = 8,
  parameter int POLL_CYCLES    = 50000,
  parameter int DEBOUNCE       = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int VEC_W = NUM_CH * BTN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             bridge_ready,
  output logic             bridge_start,
  output logic [CH_W-1:0]  bridge_chan,
  input  logic             bridge_valid,
  input  logic [BTN_W-1:0] bridge_data,
  output logic [VEC_W-1:0] state,
  output logic [VEC_W-1:0] pressed_evt,
  output logic [VEC_W-1:0] released_evt,
  input  logic [VEC_W-1:0] evt_clr,
  output logic [NUM_CH-1:0] chan_err,
  output logic             irq
);

  localparam int TMR_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [TMR_W-1:0] POLL_MAX = TMR_W'(POLL_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_NEXT} fsm_t;

  fsm_t             fsm_reg, fsm_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic [CH_W-1:0]  chan_reg, chan_next;
  logic [BTN_W-1:0] sample_reg, sample_next;
  logic             start_now;
  logic             do_update;
  logic             set_err;

  logic [VEC_W-1:0] state_vec;
  logic [VEC_W-1:0] prev_reg;
  logic [VEC_W-1:0] pressed_reg, pressed_next;
  logic [VEC_W-1:0] released_reg, released_next;
  logic             irq_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg    <= S_IDLE;
      timer_reg  <= '0;
      tmo_reg    <= '0;
      chan_reg   <= '0;
      sample_reg <= '0;
    end else begin
      fsm_reg    <= fsm_next;
      timer_reg  <= timer_next;
      tmo_reg    <= tmo_next;
      chan_reg   <= chan_next;
      sample_reg <= sample_next;
    end
  end

  // The idle timer holds at its terminal count while enable is low, so a
  // stalled poller starts immediately once enable returns.
  always_comb begin
    fsm_next    = fsm_reg;
    timer_next  = timer_reg;
    tmo_next    = tmo_reg;
    chan_next   = chan_reg;
    sample_next = sample_reg;
    start_now   = 1'b0;
    do_update   = 1'b0;
    set_err     = 1'b0;
    case (fsm_reg)
      S_IDLE: begin
        if (timer_reg == POLL_MAX) begin
          chan_next = '0;
          if (enable) fsm_next = S_ISSUE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      S_ISSUE: begin
        if (bridge_ready) begin
          start_now = 1'b1;
          tmo_next  = TMO_MAX;
          fsm_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bridge_valid) begin
          sample_next = bridge_data;
          fsm_next    = S_UPDATE;
        end else if (tmo_reg == '0) begin
          set_err  = 1'b1;
          fsm_next = S_NEXT;
        end else begin
          tmo_next = tmo_reg - 1'b1;
        end
      end
      S_UPDATE: begin
        do_update = 1'b1;
        fsm_next  = S_NEXT;
      end
      S_NEXT: begin
        if (chan_reg == CH_LAST) begin
          chan_next  = '0;
          timer_next = '0;
          fsm_next   = S_IDLE;
        end else begin
          chan_next = chan_reg + 1'b1;
          fsm_next  = S_ISSUE;
        end
      end
      default: fsm_next = S_IDLE;
    endcase
  end

  assign bridge_start = start_now;
  assign bridge_chan  = chan_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [BTN_W-1:0] cand_reg, cand_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [BTN_W-1:0] stable_reg;
      logic             err_reg;
      logic             sel;

      assign sel = (chan_reg == CH_W'(gi));

      always_comb begin
        cand_next = cand_reg;
        cnt_next  = cnt_reg;
        if (sample_reg == cand_reg) begin
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
        end else begin
          cand_next = sample_reg;
          cnt_next  = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cand_reg   <= '0;
          cnt_reg    <= '0;
          stable_reg <= '0;
          err_reg    <= 1'b0;
        end else if (do_update && sel) begin
          cand_reg <= cand_next;
          cnt_reg  <= cnt_next;
          if (cnt_next == CNT_MAX) stable_reg <= cand_next;
          err_reg  <= 1'b0;
        end else if (set_err && sel) begin
          err_reg <= 1'b1;
        end
      end

      assign state_vec[gi*BTN_W +: BTN_W] = stable_reg;
      assign chan_err[gi]                 = err_reg;
    end
  endgenerate

  // prev_reg differs from state_vec only in the cycle right after a state change.
  always_comb begin
    pressed_next  = (pressed_reg  & ~evt_clr) | (state_vec & ~prev_reg);
    released_next = (released_reg & ~evt_clr) | (~state_vec & prev_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg     <= '0;
      pressed_reg  <= '0;
      released_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      prev_reg     <= state_vec;
      pressed_reg  <= pressed_next;
      released_reg <= released_next;
      irq_reg      <= |{pressed_next, released_next};
    end
  end

  assign state        = state_vec;
  assign pressed_evt  = pressed_reg;
  assign released_evt = released_reg;
  assign irq          = irq_reg;

endmodule

// File: tb/tb_joypad_poller.sv
// tb_joypad_poller: drives a latency-based bridge model and compares the poller against a
// sample-history reference model every cycle, plus hand-computed directed expectations.
module tb_joypad_poller;
  localparam int NUM_CH = 2;
  localparam int BTN_W  = 8;
  localparam int P      = 20;
  localparam int DEB    = 2;
  localparam int T      = 20;
  localparam int L      = 10;
  localparam int W      = NUM_CH * BTN_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic bridge_ready = 1'b1;
  logic bridge_valid = 1'b0;
  logic [BTN_W-1:0] bridge_data = '0;
  logic [W-1:0] evt_clr = '0;
  logic bridge_start;
  logic [0:0] bridge_chan;
  logic [W-1:0] state, pressed_evt, released_evt;
  logic [NUM_CH-1:0] chan_err;
  logic irq;

  always #5 clk = ~clk;

  joypad_poller #(
    .NUM_CH(NUM_CH), .BTN_W(BTN_W), .POLL_CYCLES(P), .DEBOUNCE(DEB), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bridge_ready(bridge_ready),
    .bridge_start(bridge_start), .bridge_chan(bridge_chan), .bridge_valid(bridge_valid),
    .bridge_data(bridge_data), .state(state), .pressed_evt(pressed_evt),
    .released_evt(released_evt), .evt_clr(evt_clr), .chan_err(chan_err), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bridge response table
  logic [BTN_W-1:0] resp [NUM_CH];
  bit               mute [NUM_CH];

  // Reference model: a channel's stable value is its sample whenever the last DEB samples agree
  logic [W-1:0]      m_state = '0, m_prev = '0, m_press = '0, m_rel = '0;
  logic [NUM_CH-1:0] m_err = '0;
  logic              m_irq = 1'b0;
  logic [BTN_W-1:0]  hist [NUM_CH][DEB];
  bit                waiting = 0, upd_pend = 0, chg_flag = 0, start_q = 0, start_prev = 0;
  int                wcnt = 0, wait_chan = 0, exp_chan = 0, upd_chan = 0, sweeps = 0, start_cnt = 0;
  logic [BTN_W-1:0]  upd_val = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = '0; m_prev = '0; m_press = '0; m_rel = '0; m_err = '0; m_irq = 1'b0;
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < DEB; k++) hist[c][k] = '0;
      waiting = 0; upd_pend = 0; chg_flag = 0; exp_chan = 0;
    end else begin
      m_press = (m_press & ~evt_clr) | (m_state & ~m_prev);
      m_rel   = (m_rel & ~evt_clr) | (~m_state & m_prev);
      m_irq   = |{m_press, m_rel};
      m_prev  = m_state;
      chg_flag = 0;
      if (upd_pend) begin
        if (m_state[upd_chan*BTN_W +: BTN_W] != upd_val) chg_flag = 1;
        m_state[upd_chan*BTN_W +: BTN_W] = upd_val;
        m_err[upd_chan] = 1'b0;
        upd_pend = 0;
        if (upd_chan == NUM_CH-1) sweeps++;
      end
      if (waiting) begin
        if (bridge_valid) begin
          bit same;
          for (int k = DEB-1; k > 0; k--) hist[wait_chan][k] = hist[wait_chan][k-1];
          hist[wait_chan][0] = bridge_data;
          same = 1;
          for (int k = 1; k < DEB; k++) if (hist[wait_chan][k] != bridge_data) same = 0;
          upd_val  = same ? bridge_data : m_state[wait_chan*BTN_W +: BTN_W];
          upd_chan = wait_chan;
          upd_pend = 1;
          waiting  = 0;
          $display("txn ch%0d data=%h stable=%h", wait_chan, bridge_data, upd_val);
        end else begin
          wcnt++;
          if (wcnt == T) begin
            m_err[wait_chan] = 1'b1;
            waiting = 0;
            if (wait_chan == NUM_CH-1) sweeps++;
            $display("txn ch%0d timeout", wait_chan);
          end
        end
      end
      if (start_q) begin
        waiting   = 1;
        wcnt      = 0;
        wait_chan = exp_chan;
        exp_chan  = (exp_chan + 1) % NUM_CH;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    start_q = bridge_start;
    if (bridge_start) start_cnt++;
    chk("state", state, m_state);
    chk("pressed_evt", pressed_evt, m_press);
    chk("released_evt", released_evt, m_rel);
    chk("chan_err", chan_err, m_err);
    chk("irq", irq, m_irq);
    if (bridge_start) chk("start_chan", bridge_chan, exp_chan);
    if (waiting) chk("held_chan", bridge_chan, wait_chan);
    if (!bridge_ready) chk("start_while_not_ready", bridge_start, 1'b0);
    if (start_prev) chk("start_one_cycle", bridge_start, 1'b0);
    start_prev = bridge_start;
  end

  // Bridge model: valid arrives L cycles after the start cycle
  always begin
    int c;
    @(negedge clk);
    if (bridge_start && rst_n) begin
      c = int'(bridge_chan);
      repeat (L) @(posedge clk);
      #1;
      if (!mute[c] && rst_n) begin
        bridge_valid = 1'b1;
        bridge_data  = resp[c];
        @(posedge clk);
        #1;
        bridge_valid = 1'b0;
        bridge_data  = BTN_W'($urandom);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sweeps(input int n);
    int tgt, b;
    tgt = sweeps + n;
    b = 0;
    while (sweeps < tgt && b < 3000) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (sweeps < tgt) chk("sweep_bound", 64'(sweeps), 64'(tgt));
    tick(2);
  endtask

  task automatic measure_first_start();
    int n;
    n = 0;
    @(negedge clk);
    while (!bridge_start && n < P + 50) begin
      @(negedge clk);
      n++;
    end
    chk("first_start_delay", 64'(n), 64'(P));
  endtask

  task automatic wait_start_count(input int tgt, input string name);
    int b;
    b = 0;
    while (start_cnt < tgt && b < 500) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk(name, 64'(start_cnt >= tgt), 64'd1);
  endtask

  logic [BTN_W-1:0] seq [8];
  int s0, b;

  initial begin
    resp[0] = '0; resp[1] = '0; mute[0] = 0; mute[1] = 0;
    enable = 1'b1;
    tick(3);
    chk("rst_state", state, 16'h0);
    chk("rst_pressed", pressed_evt, 16'h0);
    chk("rst_released", released_evt, 16'h0);
    chk("rst_chan_err", chan_err, 2'b00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_start", bridge_start, 1'b0);

    // Two identical samples needed before state updates
    resp[0] = 8'hA5; resp[1] = 8'h3C;
    rst_n = 1'b1;
    measure_first_start();
    wait_sweeps(1);
    chk("sweep1_state", state, 16'h0000);
    wait_sweeps(1);
    chk("sweep2_state", state, 16'h3CA5);
    chk("sweep2_pressed", pressed_evt, 16'h3CA5);
    chk("sweep2_released", released_evt, 16'h0000);
    chk("sweep2_irq", irq, 1'b1);

    // Clear collides with a new press on bit 9: the set wins
    resp[1] = 8'h3E;
    wait_sweeps(1);
    b = 0;
    while (!chg_flag && b < 300) begin
      tick(1);
      b++;
    end
    chk("bit9_change_seen", 64'(chg_flag), 64'd1);
    evt_clr = '1;
    tick(1);
    evt_clr = '0;
    chk("clr_collide_pressed", pressed_evt, 16'h0200);
    chk("clr_collide_released", released_evt, 16'h0000);
    chk("clr_collide_irq", irq, 1'b1);
    evt_clr = '1;
    tick(1);
    evt_clr = '0;
    chk("clr_all_pressed", pressed_evt, 16'h0000);
    chk("clr_all_irq", irq, 1'b0);

    // Channel 1 timeout, then recovery
    mute[1] = 1;
    wait_sweeps(1);
    chk("timeout_err", chan_err, 2'b10);
    chk("timeout_state", state, 16'h3EA5);
    mute[1] = 0;
    wait_sweeps(1);
    chk("recover_err", chan_err, 2'b00);

    // Ready held low: no start, then exactly one start on release
    bridge_ready = 1'b0;
    s0 = start_cnt;
    tick(P + 50);
    chk("no_start_ready_low", 64'(start_cnt - s0), 64'd0);
    bridge_ready = 1'b1;
    s0 = start_cnt;
    tick(3);
    chk("one_start_on_ready", 64'(start_cnt - s0), 64'd1);
    wait_sweeps(1);

    // Debounce: alternating samples never settle, steady pairs do
    seq = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
    rst_n = 1'b0;
    tick(2);
    resp[0] = seq[0]; resp[1] = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      resp[0] = seq[i];
      wait_sweeps(1);
      if (i == 3) begin
        chk("alt_state", state, 16'h0000);
        chk("alt_pressed", pressed_evt, 16'h0000);
        chk("alt_released", released_evt, 16'h0000);
      end
      if (i == 6) chk("press_after_3", pressed_evt[0], 1'b0);
      if (i == 7) begin
        chk("press_after_4", pressed_evt[0], 1'b1);
        chk("state_after_4", state, 16'h0001);
      end
    end

    // Enable dropped mid-sweep, then reset during channel 1 wait
    s0 = start_cnt;
    wait_start_count(s0 + 1, "ch0_start");
    tick(3);
    enable = 1'b0;
    wait_start_count(s0 + 2, "sweep_finishes_after_disable");
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", state, 16'h0);
    chk("midrst_pressed", pressed_evt, 16'h0);
    chk("midrst_released", released_evt, 16'h0);
    chk("midrst_err", chan_err, 2'b00);
    chk("midrst_irq", irq, 1'b0);
    chk("midrst_start", bridge_start, 1'b0);
    tick(2);
    enable = 1'b1;
    rst_n = 1'b1;
    measure_first_start();
    wait_sweeps(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
